// File: rtl/ofdm_tx_symbol_builder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ofdm_tx_symbol_builder
// Description : Transmit frequency-domain assembler. Emits one LTS symbol and
//               then NSYM data symbols of 64 bins in natural FFT order. Each
//               data symbol carries 48 QPSK symbols plus pilots and nulls.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ofdm_tx_symbol_builder #(
   parameter int WIDTH = 16,
   parameter int NSYM  = 4,
   parameter int QAMP  = 11585,
   parameter int PAMP  = 16384
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_sym_valid,
   input  logic [1:0]       i_sym,
   output logic             o_sym_ready,
   output logic             o_do_en,
   output logic [WIDTH-1:0] o_do_re,
   output logic [WIDTH-1:0] o_do_im,
   output logic             o_do_sof,
   output logic             o_lts_out,
   output logic             o_busy,
   output logic             o_done
);

   localparam int              SW         = $clog2(NSYM) + 1;
   localparam logic [SW-1:0]   c_SYM_LAST = SW'(NSYM - 1);
   localparam logic [WIDTH-1:0] c_QP      = WIDTH'(QAMP);
   localparam logic [WIDTH-1:0] c_QM      = WIDTH'(-QAMP);
   localparam logic [WIDTH-1:0] c_PP      = WIDTH'(PAMP);
   localparam logic [WIDTH-1:0] c_PM      = WIDTH'(-PAMP);

   // LTS ROM codes: 00 = zero, 01 = +1, 11 = -1; indexed by bin k
   localparam logic [1:0] c_Z = 2'b00;
   localparam logic [1:0] c_P = 2'b01;
   localparam logic [1:0] c_M = 2'b11;
   localparam logic [1:0] c_LTS_ROM [0:63] = '{
      c_Z, c_P, c_M, c_M, c_P, c_P, c_M, c_P,
      c_M, c_P, c_M, c_M, c_M, c_M, c_M, c_P,
      c_P, c_M, c_M, c_P, c_M, c_P, c_M, c_P,
      c_P, c_P, c_P, c_Z, c_Z, c_Z, c_Z, c_Z,
      c_Z, c_Z, c_Z, c_Z, c_Z, c_Z, c_P, c_P,
      c_M, c_M, c_P, c_P, c_M, c_P, c_M, c_P,
      c_P, c_P, c_P, c_P, c_P, c_M, c_M, c_P,
      c_P, c_M, c_P, c_M, c_P, c_P, c_P, c_P
   };

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LTS  = 3'd1,
      S_FILL = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           r_state, w_state_n;
   logic [5:0]       r_bin, w_bin_n;
   logic [5:0]       r_didx, w_didx_n;
   logic [SW-1:0]    r_symcnt, w_symcnt_n;
   logic             w_xfer;
   logic [1:0]       r_buf [0:47];

   logic [5:0]       w_rd_idx;
   logic [1:0]       w_rd_sym;
   logic             w_is_null, w_is_pilot;
   logic             w_en_n, w_sof_n;
   logic [WIDTH-1:0] w_re_n, w_im_n;

   // Next-state and counter sequencing
   always_comb begin
      w_state_n  = r_state;
      w_bin_n    = r_bin;
      w_didx_n   = r_didx;
      w_symcnt_n = r_symcnt;
      w_xfer     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_n  = S_LTS;
               w_bin_n    = 6'd0;
               w_didx_n   = 6'd0;
               w_symcnt_n = '0;
            end
         end
         S_LTS: begin
            w_bin_n = r_bin + 6'd1;
            if (r_bin == 6'd63) w_state_n = S_FILL;
         end
         S_FILL: begin
            if (i_sym_valid) begin
               w_xfer   = 1'b1;
               w_didx_n = r_didx + 6'd1;
               if (r_didx == 6'd47) begin
                  w_state_n = S_EMIT;
                  w_didx_n  = 6'd0;
                  w_bin_n   = 6'd0;
               end
            end
         end
         S_EMIT: begin
            w_bin_n = r_bin + 6'd1;
            if (r_bin == 6'd63) begin
               if (r_symcnt != c_SYM_LAST) begin
                  w_symcnt_n = r_symcnt + 1'b1;
                  w_state_n  = S_FILL;
               end else begin
                  w_state_n = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_state_n  = S_IDLE;
            w_symcnt_n = '0;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Bin content for the cycle after this edge (outputs are registered)
   always_comb begin
      w_is_null  = (w_bin_n == 6'd0) || ((w_bin_n >= 6'd27) && (w_bin_n <= 6'd37));
      w_is_pilot = (w_bin_n == 6'd7) || (w_bin_n == 6'd21) ||
                   (w_bin_n == 6'd43) || (w_bin_n == 6'd57);
      // data index: skip the pilots below k, and the null gap for upper bins
      if (w_bin_n <= 6'd26)
         w_rd_idx = w_bin_n - 6'd1 - {5'd0, w_bin_n > 6'd7} - {5'd0, w_bin_n > 6'd21};
      else
         w_rd_idx = w_bin_n - 6'd14 - {5'd0, w_bin_n > 6'd43} - {5'd0, w_bin_n > 6'd57};
      w_rd_sym = (w_rd_idx < 6'd48) ? r_buf[w_rd_idx] : 2'b00;

      w_en_n  = (w_state_n == S_LTS) || (w_state_n == S_EMIT);
      w_sof_n = w_en_n && (w_bin_n == 6'd0);
      w_re_n  = '0;
      w_im_n  = '0;
      if (w_state_n == S_LTS) begin
         case (c_LTS_ROM[w_bin_n])
            c_P:     w_re_n = c_PP;
            c_M:     w_re_n = c_PM;
            default: w_re_n = '0;
         endcase
      end else if (w_state_n == S_EMIT && !w_is_null) begin
         if (w_is_pilot) begin
            w_re_n = (w_bin_n == 6'd21) ? c_PM : c_PP;
         end else begin
            w_re_n = w_rd_sym[1] ? c_QM : c_QP;
            w_im_n = w_rd_sym[0] ? c_QM : c_QP;
         end
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_bin       <= 6'd0;
         r_didx      <= 6'd0;
         r_symcnt    <= '0;
         o_sym_ready <= 1'b0;
         o_do_en     <= 1'b0;
         o_do_re     <= '0;
         o_do_im     <= '0;
         o_do_sof    <= 1'b0;
         o_lts_out   <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_bin       <= w_bin_n;
         r_didx      <= w_didx_n;
         r_symcnt    <= w_symcnt_n;
         o_sym_ready <= (w_state_n == S_FILL);
         o_do_en     <= w_en_n;
         o_do_re     <= w_re_n;
         o_do_im     <= w_im_n;
         o_do_sof    <= w_sof_n;
         o_lts_out   <= (w_state_n == S_LTS);
         o_busy      <= (w_state_n != S_IDLE);
         o_done      <= (w_state_n == S_DONE);
      end
   end

   // Symbol buffer write; contents need no reset
   always_ff @(posedge i_clk) begin
      if (w_xfer) r_buf[r_didx] <= i_sym;
   end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_tx_symbol_builder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ofdm_tx_symbol_builder
// Description : Self-checking bench for ofdm_tx_symbol_builder with an
//               expected-bin queue filled per frame and drained by a monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ofdm_tx_symbol_builder;

   localparam int WIDTH = 16;
   localparam int NSYM  = 4;
   localparam int TOTAL = 48 * NSYM;
   localparam logic [15:0] QP = 16'd11585;
   localparam logic [15:0] QM = 16'hD2BF;   // -11585
   localparam logic [15:0] PP = 16'd16384;
   localparam logic [15:0] PM = 16'hC000;   // -16384

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_start, i_sym_valid;
   logic [1:0]       i_sym;
   logic             o_sym_ready, o_do_en, o_do_sof, o_lts_out, o_busy, o_done;
   logic [WIDTH-1:0] o_do_re, o_do_im;

   ofdm_tx_symbol_builder #(.WIDTH(WIDTH), .NSYM(NSYM), .QAMP(11585), .PAMP(16384)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_sym_valid(i_sym_valid),
      .i_sym(i_sym), .o_sym_ready(o_sym_ready), .o_do_en(o_do_en), .o_do_re(o_do_re),
      .o_do_im(o_do_im), .o_do_sof(o_do_sof), .o_lts_out(o_lts_out), .o_busy(o_busy),
      .o_done(o_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
      logic        sof;
      logic        lts;
   } exp_t;

   exp_t  q[$];
   int    n_tests = 0, n_fail = 0;
   int    n_en = 0, n_data_en = 0, n_done = 0, run = 0;
   bit    prev_done = 0;
   logic [1:0] syms [0:TOTAL-1];
   string LNEG = "++--++-+-++++++--++-+-++++";   // L(-26..-1)
   string LPOS = "+--++-+-+-----++--+-+-++++";   // L(+1..+26)

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected reference: LTS from the L strings, then data symbols in ascending k
   function automatic void push_frame();
      exp_t e;
      int   s, d;
      byte  c;
      for (int k = 0; k < 64; k++) begin
         e.lts = 1'b1; e.sof = (k == 0); e.im = '0; e.re = '0;
         s = (k < 32) ? k : k - 64;
         if (s >= 1 && s <= 26) begin
            c = LPOS[s-1]; e.re = (c == "+") ? PP : PM;
         end else if (s >= -26 && s <= -1) begin
            c = LNEG[s+26]; e.re = (c == "+") ? PP : PM;
         end
         q.push_back(e);
      end
      d = 0;
      for (int n = 0; n < NSYM; n++) begin
         for (int k = 0; k < 64; k++) begin
            e.lts = 1'b0; e.sof = (k == 0); e.re = '0; e.im = '0;
            if (k == 0 || (k >= 27 && k <= 37)) begin
               // null
            end else if (k == 21) begin
               e.re = PM;
            end else if (k == 7 || k == 43 || k == 57) begin
               e.re = PP;
            end else begin
               e.re = syms[d][1] ? QM : QP;
               e.im = syms[d][0] ? QM : QP;
               d++;
            end
            q.push_back(e);
         end
      end
   endfunction

   // Output monitor: drains the queue and checks protocol on every cycle
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         run = 0;
         prev_done = 0;
      end else begin
         if (o_do_en) begin
            n_en++;
            run++;
            if (!o_lts_out) n_data_en++;
            if (q.size() == 0) begin
               chk("unexpected_bin", 1, 0);
            end else begin
               e = q.pop_front();
               chk("bin_re", o_do_re, e.re);
               chk("bin_im", o_do_im, e.im);
               chk("bin_sof", o_do_sof, e.sof);
               chk("bin_lts", o_lts_out, e.lts);
            end
         end else begin
            chk("idle_zero", {o_do_re, o_do_im, o_do_sof, o_lts_out}, 0);
            if (run != 0) begin
               chk("en_run_len", run, 64);
               run = 0;
            end
         end
         if (o_do_en || o_done) chk("ready_low", o_sym_ready, 0);
         if (o_done) begin
            n_done++;
            chk("busy_at_done", o_busy, 1);
         end
         if (prev_done) chk("busy_after_done", o_busy, 0);
         prev_done = o_done;
      end
   end

   // mode: 0 all zero, 1 counting 0..3, 2 random; vpct = sym_valid probability
   task automatic run_frame(input int mode, input int vpct, input bit inj_start, input bit abort);
      int  idx, cyc;
      bit  pend;
      for (int i = 0; i < TOTAL; i++)
         syms[i] = (mode == 0) ? 2'd0 : (mode == 1) ? 2'(i % 4) : 2'($urandom_range(3));
      q.delete();
      push_frame();
      n_en = 0; n_data_en = 0; n_done = 0;
      @(negedge clk); #1;
      i_start = 1'b1; i_sym_valid = 1'b0;
      @(negedge clk); #1;
      i_start = 1'b0;
      idx = 0; pend = 0; cyc = 0;
      while (n_done == 0 && cyc < 4000) begin
         if (abort && n_data_en == 31) break;
         if (pend) idx++;
         i_sym_valid = ($urandom_range(99) < vpct);
         i_sym       = (idx < TOTAL) ? syms[idx] : 2'($urandom_range(3));
         pend        = o_sym_ready && i_sym_valid;
         i_start     = inj_start && o_do_en && !o_lts_out;
         @(negedge clk); #1;
         cyc++;
      end
      i_start = 1'b0;
      i_sym_valid = 1'b0;
      if (abort) begin
         chk("abort_reached_bin30", n_data_en, 31);
         rst_n = 1'b0;
         #1;
         chk("abort_async_zero", {o_sym_ready, o_do_en, o_do_re, o_do_im, o_do_sof,
                                  o_lts_out, o_busy, o_done}, 0);
         repeat (3) @(negedge clk);
         chk("abort_no_done", n_done, 0);
         q.delete();
         #1 rst_n = 1'b1;
         repeat (2) @(negedge clk);
         chk("abort_idle_busy", o_busy, 0);
      end else begin
         chk("frame_timeout", (cyc >= 4000), 0);
         repeat (3) @(negedge clk);
         #1;
         chk("done_count", n_done, 1);
         chk("data_en_cycles", n_data_en, NSYM * 64);
         chk("lts_en_cycles", n_en - n_data_en, 64);
         chk("queue_empty", q.size(), 0);
         chk("syms_consumed", idx, TOTAL);
         chk("idle_after_frame", {o_busy, o_sym_ready, o_do_en}, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_sym_valid = 1'b0; i_sym = 2'd0;
      // reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         i_start = 1'($urandom_range(1)); i_sym_valid = 1'($urandom_range(1));
         i_sym = 2'($urandom_range(3));
         #1;
         chk("reset_outputs", {o_sym_ready, o_do_en, o_do_re, o_do_im, o_do_sof,
                               o_lts_out, o_busy, o_done}, 0);
      end
      i_start = 1'b0; i_sym_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      // released without start: remain idle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         i_sym_valid = 1'($urandom_range(1));
         chk("post_reset_idle", {o_sym_ready, o_do_en, o_do_re, o_do_im, o_do_sof,
                                 o_lts_out, o_busy, o_done}, 0);
      end
      i_sym_valid = 1'b0;
      run_frame(0, 100, 1'b0, 1'b0);   // basic frame
      run_frame(1, 100, 1'b1, 1'b0);   // mapping/order, start pulsed during EMIT
      run_frame(0, 50,  1'b0, 1'b0);   // backpressure
      run_frame(2, 50,  1'b0, 1'b0);   // random symbols with backpressure
      run_frame(1, 100, 1'b0, 1'b1);   // abort at EMIT bin 30
      run_frame(2, 70,  1'b0, 1'b0);   // full frame after abort
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ofdm_tx_symbol_builder.md
Name: ofdm_tx_symbol_builder

Overview: Transmit-side frequency-domain assembler. It is the mirror of the receiver chain's demapper and equaliser output, which produces sym and valid_final. It takes 2-bit QPSK symbols over a ready/valid handshake and maps them to Q2.14 constellation points. It inserts pilots and nulls, prepends one LTS symbol, and streams 64-bin frames in natural FFT order to the transmit IFFT, with the same do_en/re/im style and an lts flag that pairs with the receiver's lts_in.

Parameters:
WIDTH, 16, sample width of do_re/do_im (two's complement, Q2.14).
NSYM, 4, data OFDM symbols per frame (48*NSYM QPSK symbols).
QAMP, 11585, QPSK component magnitude (1/sqrt2 in Q2.14).
PAMP, 16384, pilot/LTS magnitude (1.0 in Q2.14).

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  frame request; sampled only in IDLE.
sym_valid  in  1  sym holds a valid QPSK symbol.
sym  in  2  QPSK bits {b1,b0}.
sym_ready  out  1  block accepts sym this cycle.
do_en  out  1  output bin valid.
do_re  out  WIDTH  bin real part.
do_im  out  WIDTH  bin imaginary part.
do_sof  out  1  high with bin 0 of each 64-bin symbol.
lts_out  out  1  high for all 64 bins of the LTS symbol.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after the last bin of the frame.

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0 immediately (asynchronous); bin, data and symbol counters cleared; buffer contents are don't-care. Reset mid-frame aborts the frame; no done pulse.
- All outputs registered. do_re/do_im = 0 whenever do_en=0.
- FSM:
  - IDLE: start=1 -> LTS. start in any other state is ignored.
  - LTS: 64 cycles, bins k=0..63; do_en=lts_out=1; then -> FILL.
  - FILL: sym_ready=1, a Moore output of state. A transfer occurs when sym_valid&sym_ready at a rising edge; the symbol is written to buf[d], d=0..47. The 48th transfer moves to EMIT at the same edge, so sym_ready is 0 the next cycle and no overrun is possible. Gaps in sym_valid stall FILL indefinitely.
  - EMIT: 64 consecutive cycles of do_en=1, bins k=0..63, do_sof at k=0. On k=63: if the symbol count is below NSYM-1, increment and -> FILL; otherwise -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency: first LTS bin (do_en=1) appears on the cycle after start is sampled. A data symbol's first bin appears on the cycle after the 48th transfer.
- Bin k maps to subcarrier k for k<32, and to subcarrier k-64 for k>=32.
- EMIT bin contents:
  - Nulls: k=0 and k=27..37 -> (0,0).
  - Pilots, im=0: k=7 re=+PAMP; k=21 re=-PAMP; k=43 re=+PAMP; k=57 re=+PAMP.
  - Data bins: the remaining 48 (k=1..26 and 38..63, minus pilots), consumed in ascending k. d=0 is at k=1, d=23 at k=26, d=24 at k=38, d=47 at k=63.
  - QPSK mapping: re = b1 ? -QAMP : +QAMP; im = b0 ? -QAMP : +QAMP.
- LTS bin contents: im=0; re=0 for k=0 and 27..37; otherwise re=+PAMP or -PAMP per L(s).
  - L(-26..-1) = +,+,-,-,+,+,-,+,-,+,+,+,+,+,+,-,-,+,+,-,+,-,+,+,+,+
  - L(+1..+26) = +,-,-,+,+,-,+,-,+,-,-,-,-,-,+,+,-,-,+,-,+,-,+,+,+,+
  - Hold L in a constant 64-entry ROM of 2-bit codes {0,+1,-1}.
- Counters: 6-bit bin counter wraps 63->0; 6-bit data index; symbol counter of width clog2(NSYM)+1.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0; release, no start -> outputs stay 0, sym_ready=0.
- Basic frame (NSYM=4, all sym=2'b00, sym_valid constant): start -> 64 LTS bins with lts_out=1, bin1 re=+16384, bin2 re=-16384, bin63 re=+16384, bin0 and 27..37 zero. Then 4 symbols, each: data bins (11585,11585), bin21 re=-16384, bins 7/43/57 re=+16384, nulls 0, do_sof on bin0. Exactly 4*64 data-phase do_en cycles; done pulses once; busy falls with done.
- Mapping/order: feed 0,1,2,3 repeating -> bin1 (11585,11585), bin2 (11585,-11585), bin3 (-11585,11585), bin4 (-11585,-11585). d=47 (value 3) appears at bin63.
- Backpressure: random 50% sym_valid -> bin stream identical to the basic frame. do_en contiguous for 64 cycles per symbol. sym_ready=0 throughout LTS/EMIT/DONE, and sym presented then is not consumed.
- Ignored start / abort: pulse start during EMIT -> no effect. Assert reset at EMIT bin 30 -> outputs 0 asynchronously, no done. New start -> full correct frame.
